sm_register_cwe: RTL and testbench

- Register primitive pair for the schoolMIPS AHB-Lite peripheral wrappers (e.g. the Ethernet slave).
- Channel C is a plain register loaded every cycle. It captures pipelined control flags such as the write-request and read-after-write hazard bits.
- Channel WE is a write-enabled register. It holds the address phase (HADDR) of the last accepted transfer for use in the following data phase.
- Both channels share one clock and one synchronous active-low reset.

---
 rtl/sm_register_cwe.sv | 46 ++++
 tb/tb_sm_register_cwe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sm_register_cwe.sv
// Register primitive pair for the AHB-Lite peripheral wrappers: channel C loads every cycle,
// channel WE loads only when we is high. Both share one clock and a synchronous active-low reset.
module sm_register_cwe #(
  parameter int unsigned          WIDTH_C  = 1,
  parameter int unsigned          WIDTH_WE = 32,
  parameter logic [WIDTH_C-1:0]   RST_C    = '0,
  parameter logic [WIDTH_WE-1:0]  RST_WE   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH_C-1:0]  d_c,
  output logic [WIDTH_C-1:0]  q_c,
  input  logic                we,
  input  logic [WIDTH_WE-1:0] d_we,
  output logic [WIDTH_WE-1:0] q_we
);

  // Declaration initialisers give the power-up value before the first reset edge.
  logic [WIDTH_C-1:0]  q_c_q  = RST_C;
  logic [WIDTH_C-1:0]  q_c_d;
  logic [WIDTH_WE-1:0] q_we_q = RST_WE;
  logic [WIDTH_WE-1:0] q_we_d;

  always_comb begin
    q_c_d  = d_c;
    q_we_d = q_we_q;
    if (we) begin
      q_we_d = d_we;
    end
  end

  // Reset is sampled on the clock edge only and overrides both load paths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_c_q  <= RST_C;
      q_we_q <= RST_WE;
    end else begin
      q_c_q  <= q_c_d;
      q_we_q <= q_we_d;
    end
  end

  assign q_c  = q_c_q;
  assign q_we = q_we_q;

endmodule

// File: tb/tb_sm_register_cwe.sv
// Scoreboarded bench for sm_register_cwe: default-parameter instance plus an overridden-width
// instance sharing clock and reset.
module tb_sm_register_cwe;

  typedef struct packed {
    logic        c;
    logic [31:0] we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  d_c;
  logic [0:0]  q_c;
  logic        we;
  logic [31:0] d_we;
  logic [31:0] q_we;

  logic [3:0]  d_c2;
  logic [3:0]  q_c2;
  logic        we2;
  logic [7:0]  d_we2;
  logic [7:0]  q_we2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  exp_t        exp_q[$];
  logic        m_c;
  logic [31:0] m_we;

  always #5 clk = ~clk;

  sm_register_cwe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_c   (d_c),
    .q_c   (q_c),
    .we    (we),
    .d_we  (d_we),
    .q_we  (q_we)
  );

  sm_register_cwe #(
    .WIDTH_C  (4),
    .WIDTH_WE (8),
    .RST_C    (4'hA),
    .RST_WE   (8'h5C)
  ) u_dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .d_c   (d_c2),
    .q_c   (q_c2),
    .we    (we2),
    .d_we  (d_we2),
    .q_we  (q_we2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
  task automatic step(input logic rst, input logic dc, input logic w, input logic [31:0] dwe,
                      input string tag);
    exp_t e;
    rst_n = rst;
    d_c   = dc;
    we    = w;
    d_we  = dwe;
    if (!rst) begin
      m_c  = 1'b0;
      m_we = 32'h0;
    end else begin
      m_c = dc;
      if (w) m_we = dwe;
    end
    e.c  = m_c;
    e.we = m_we;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".q_c"}, 32'(q_c), 32'(e.c));
    check_eq({tag, ".q_we"}, q_we, e.we);
  endtask

  initial begin
    logic [4:0] pat;
    pat   = 5'b01101;
    rst_n = 1'b1;
    d_c   = '0;
    we    = 1'b0;
    d_we  = '0;
    d_c2  = '0;
    we2   = 1'b0;
    d_we2 = '0;
    m_c   = 1'b0;
    m_we  = 32'h0;

    #1;
    check_eq("powerup.q_c", 32'(q_c), 32'h0);
    check_eq("powerup.q_we", q_we, 32'h0);
    check_eq("powerup.q_c2", 32'(q_c2), 32'hA);
    check_eq("powerup.q_we2", 32'(q_we2), 32'h5C);

    step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "rst0");
    step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "rst1");
    check_eq("prm_rst.q_c2", 32'(q_c2), 32'hA);
    check_eq("prm_rst.q_we2", 32'(q_we2), 32'h5C);
    d_c2 = 4'h3;
    step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, "rst_rel");
    check_eq("prm_load.q_c2", 32'(q_c2), 32'h3);
    check_eq("prm_hold.q_we2", 32'(q_we2), 32'h5C);

    // pat bit 0 first: 1,0,1,1,0
    for (int i = 0; i < 5; i++) step(1'b1, pat[i], 1'b0, 32'h0, $sformatf("cpipe%0d", i));

    step(1'b1, 1'b0, 1'b1, 32'h1000_0004, "we_load");
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0, $urandom, $sformatf("we_hold%0d", i));

    step(1'b1, 1'b1, 1'b1, 32'h0000_0000, "b2b0");
    step(1'b1, 1'b0, 1'b1, 32'h0000_0004, "b2b1");
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, "b2b2");

    step(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, "a5_load");
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check_eq("async_pulse.q_we", q_we, 32'hA5A5A5A5);
    check_eq("async_pulse.q_c", 32'(q_c), 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h1234_5678, "sync_rst");
    step(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, "resume");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
